// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: parametrised floating-point add/subtract, operand register + 3 compute stages,
// valid/ready handshake, round-to-nearest-even, flush-to-zero, {invalid, overflow, underflow, inexact}.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   op_a_i,
    input  logic [EXP_W+MAN_W:0]   op_b_i,
    input  logic                   sub_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [EXP_W+MAN_W:0]   res_o,
    output logic [3:0]             flags_o
);
    localparam int E  = EXP_W;
    localparam int M  = MAN_W;
    localparam int SW = M + 4;
    localparam int LW = $clog2(SW);
    localparam int XW = E + 2;
    localparam logic [E-1:0] FAR = E'(M + 3);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << E) - 1);

    logic adv, v0_q, v1_q, v2_q, v3_q, sub_q;
    logic [E+M:0] a_q, b_q, res_q, res_d;
    logic [3:0] flags_q, flags_d;
    logic sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, inf_cl, swap, far;
    logic [E-1:0] ea, eb, diff;
    logic [M-1:0] fa, fb;
    logic [M:0] siga, sigb, ms;
    logic [2*M+3:0] wide;
    logic s1_sign_d, s1_sub_d, s1_sign_q, s1_sub_q;
    logic [E-1:0] s1_exp_d, s1_exp_q;
    logic [SW-1:0] s1_sl_d, s1_ss_d, s1_sl_q, s1_ss_q;
    logic [3:0] s1_spec_d, s1_spec_q, s2_spec_q;
    logic [SW:0] s2_sum_d, s2_sum_q;
    logic [LW-1:0] s2_lzc_d, s2_lzc_q;
    logic s2_sign_q, s2_sub_q;
    logic [E-1:0] s2_exp_q;
    logic carry;
    logic [SW-1:0] norm;
    logic [M+1:0] rnd;
    logic [M-1:0] frac;
    logic signed [XW-1:0] ex, exn, exr;

    assign adv = ~(v3_q & ~out_ready_i);
    assign in_ready_o = adv;
    assign out_valid_o = v3_q;
    assign res_o = res_q;
    assign flags_o = flags_q;

    // Denormal inputs are flushed to zero before the magnitude compare.
    assign sa = a_q[E+M];
    assign sb = b_q[E+M] ^ sub_q;
    assign {ea, fa} = a_q[E+M-1:0];
    assign {eb, fb} = b_q[E+M-1:0];
    assign za = ~|ea;
    assign zb = ~|eb;
    assign inf_a = &ea & ~|fa;
    assign inf_b = &eb & ~|fb;
    assign nan_a = &ea & |fa;
    assign nan_b = &eb & |fb;
    assign inf_cl = inf_a & inf_b & (sa ^ sb);
    assign siga = za ? '0 : {1'b1, fa};
    assign sigb = zb ? '0 : {1'b1, fb};
    assign swap = (zb ? '0 : {eb, fb}) > (za ? '0 : {ea, fa});
    assign s1_sign_d = swap ? sb : sa;
    assign s1_exp_d = swap ? eb : ea;
    assign s1_sl_d = {swap ? sigb : siga, 3'b000};
    assign ms = swap ? siga : sigb;
    assign diff = s1_exp_d - (swap ? ea : eb);
    assign wide = {ms, {(M+3){1'b0}}} >> diff;
    assign far = diff >= FAR;
    assign s1_ss_d = far ? {{(SW-1){1'b0}}, |ms} : {wide[2*M+3 -: M+3], |wide[M:0]};
    assign s1_sub_d = sa ^ sb;
    assign s1_spec_d = {nan_a | nan_b | inf_cl,
                        (nan_a & ~fa[M-1]) | (nan_b & ~fb[M-1]) | inf_cl,
                        inf_a | inf_b, inf_a ? sa : sb};

    assign s2_sum_d = s1_sub_q ? {1'b0, s1_sl_q} - {1'b0, s1_ss_q} : {1'b0, s1_sl_q} + {1'b0, s1_ss_q};

    always_comb begin
        s2_lzc_d = '0;
        for (int i = 0; i < SW; i++)
            if (s2_sum_d[i]) s2_lzc_d = LW'(SW - 1 - i);
    end

    // Carry-out folds the dropped bit into sticky; otherwise shift the leading one to the top.
    always_comb begin
        ex = {2'b00, s2_exp_q};
        carry = s2_sum_q[SW];
        norm = carry ? {s2_sum_q[SW:2], |s2_sum_q[1:0]} : s2_sum_q[SW-1:0] << s2_lzc_q;
        exn = carry ? ex + XW'(1) : ex - XW'(s2_lzc_q);
        rnd = {1'b0, norm[SW-1:3]} + (M+2)'(norm[2] & (norm[1] | norm[0] | norm[3]));
        exr = exn + XW'(rnd[M+1]);
        frac = rnd[M+1] ? rnd[M:1] : rnd[M-1:0];
        {res_d, flags_d} = s2_spec_q[3] ? {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}, s2_spec_q[2], 3'b000}
                         : s2_spec_q[1] ? {s2_spec_q[0], {E{1'b1}}, {M{1'b0}}, 4'b0000}
                         : ~|s2_sum_q   ? {s2_sign_q & ~s2_sub_q, {(E+M){1'b0}}, 4'b0000}
                         : exr >= EMAX  ? {s2_sign_q, {E{1'b1}}, {M{1'b0}}, 4'b0101}
                         : exn[XW-1] | ~|exn ? {s2_sign_q, {(E+M){1'b0}}, 4'b0011}
                         : {s2_sign_q, exr[E-1:0], frac, 3'b000, |norm[2:0]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {v0_q, v1_q, v2_q, v3_q} <= '0;
            res_q <= '0;
            flags_q <= '0;
        end else if (adv) begin
            {v0_q, v1_q, v2_q, v3_q} <= {in_valid_i, v0_q, v1_q, v2_q};
            if (v2_q) begin
                res_q <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv) begin
            {a_q, b_q, sub_q} <= {op_a_i, op_b_i, sub_i};
            {s1_sign_q, s1_exp_q, s1_sl_q, s1_ss_q, s1_sub_q, s1_spec_q} <=
                {s1_sign_d, s1_exp_d, s1_sl_d, s1_ss_d, s1_sub_d, s1_spec_d};
            {s2_sign_q, s2_exp_q, s2_sum_q, s2_lzc_q, s2_sub_q, s2_spec_q} <=
                {s1_sign_q, s1_exp_q, s2_sum_d, s2_lzc_d, s1_sub_q, s1_spec_q};
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed and streamed checks of fp_addsub_pipe with a result scoreboard.
module tb_fp_addsub_pipe;
    logic clk = 0, rst = 1, in_valid = 0, sub = 0, out_ready = 1, rnd = 0;
    logic [31:0] a = 0, b = 0, res;
    logic in_ready, out_valid;
    logic [3:0] flags;
    logic d_valid = 0, d_in_ready, d_out_valid;
    logic [63:0] da = 0, db = 0, dres;
    logic [3:0] dflags;
    int checks = 0, failures = 0;
    logic [35:0] sb[$];
    logic stalled_prev = 0;
    logic [35:0] prev = 0;

    fp_addsub_pipe dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_a_i(a), .op_b_i(b), .sub_i(sub), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .res_o(res), .flags_o(flags)
    );

    fp_addsub_pipe #(.EXP_W(11), .MAN_W(52)) dut_d (
        .clk_i(clk), .rst_i(rst), .in_valid_i(d_valid), .in_ready_o(d_in_ready),
        .op_a_i(da), .op_b_i(db), .sub_i(1'b0), .out_valid_o(d_out_valid),
        .out_ready_i(1'b1), .res_o(dres), .flags_o(dflags)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] s2d(logic [31:0] x);
        return {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
    endfunction

    // Double-precision sum is exact for the operand range used, then rounded to single (RNE).
    function automatic logic [35:0] ref_add(logic [31:0] x, logic [31:0] y, logic s);
        real rx, ry;
        logic [63:0] r;
        logic [31:0] o;
        logic up;
        rx = $bitstoreal(s2d(x));
        ry = $bitstoreal(s2d(y));
        r = $realtobits(s ? rx - ry : rx + ry);
        if (r[62:0] == 63'd0) return 36'd0;
        up = r[28] & ((|r[27:0]) | r[29]);
        o = {r[63], 8'(r[62:52] - 11'd896), r[51:29]} + 32'(up);
        return {o, 3'b000, |r[28:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (stalled_prev) chk("hold", 64'({res, flags}), 64'(prev));
            if (out_valid && out_ready) begin
                chk("unexpected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("result", 64'({res, flags}), 64'(sb.pop_front()));
            end
            stalled_prev = out_valid && !out_ready;
            prev = {res, flags};
        end else stalled_prev = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
    endtask

    task automatic send(logic [31:0] x, logic [31:0] y, logic s, logic [35:0] e);
        logic acc;
        int n;
        n = 0;
        in_valid = 1; a = x; b = y; sub = s;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        in_valid = 0;
        chk("accept", 64'(acc), 64'd1);
        if (acc) sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] x, y;
        logic s;
        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst = 0;
        tick();
        send(32'h3f800000, 32'h40200000, 0, {32'h40600000, 4'h0});
        tick(); tick();
        chk("lat_n2", 64'(out_valid), 64'd0);
        tick();
        chk("lat_n3", 64'(out_valid), 64'd1);
        drain();
        send(32'hbf800000, 32'h40200000, 0, {32'h3fc00000, 4'h0});
        send(32'h3f800000, 32'hc0200000, 0, {32'hbfc00000, 4'h0});
        send(32'hbf800000, 32'hc0200000, 0, {32'hc0600000, 4'h0});
        send(32'hbecccccd, 32'h3e99999a, 0, {32'hbdcccccc, 4'h0});
        send(32'h40200000, 32'h40200000, 1, {32'h00000000, 4'h0});
        send(32'h3f800000, 32'h33800000, 0, {32'h3f800000, 4'h1});
        send(32'h7f7fffff, 32'h7f7fffff, 0, {32'h7f800000, 4'h5});
        send(32'h7f800000, 32'hff800000, 0, {32'h7fc00000, 4'h8});
        send(32'h7fc00000, 32'h3f800000, 0, {32'h7fc00000, 4'h0});
        send(32'h00400000, 32'h3f800000, 0, {32'h3f800000, 4'h0});
        send(32'h80000000, 32'h80000000, 0, {32'h80000000, 4'h0});
        drain();
        rnd = 1;
        for (int i = 0; i < 8; i++) begin
            x = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
            y = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
            s = 1'($urandom_range(0, 1));
            send(x, y, s, ref_add(x, y, s));
        end
        for (int i = 0; i < 20; i++) tick();
        rnd = 0;
        drain();
        send(32'h3f800000, 32'h3f800000, 0, {32'h40000000, 4'h0});
        send(32'h40000000, 32'h3f800000, 0, {32'h40400000, 4'h0});
        tick();
        rst = 1;
        tick();
        chk("rst_flush", 64'(out_valid), 64'd0);
        sb.delete();
        rst = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("no_stale", 64'(out_valid), 64'd0);
        da = 64'h3ff0000000000000;
        db = 64'h4004000000000000;
        d_valid = 1;
        tick();
        d_valid = 0;
        for (int i = 0; i < 10 && !d_out_valid; i++) tick();
        chk("dp_valid", 64'(d_out_valid), 64'd1);
        chk("dp_res", dres, 64'h400c000000000000);
        chk("dp_flags", 64'(dflags), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
